// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: sequential pc fetcher feeding a small instruction queue.
// Redirect flushes the queue and restarts fetch at the new pc.
module instr_fetch_unit #(
  parameter int unsigned ADDR_W = 8,
  parameter int unsigned DEPTH  = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fetch_en,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic [3:0]        opcode,
  output logic [11:0]       operand,
  output logic              valid,
  input  logic              ready,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_addr,
  output logic              idle
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    WAIT_SPACE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;
  logic [ADDR_W-1:0] r_pc;
  logic [CNT_W-1:0]  r_count;
  logic [CNT_W-1:0]  w_count_next;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [PTR_W-1:0]  r_wr_ptr;
  logic [15:0]       r_mem [DEPTH];
  logic              w_full;
  logic              w_push;
  logic              w_pop;

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + PTR_W'(1);
  endfunction

  assign w_full = (r_count == FULL_CNT);
  assign w_pop  = valid && ready;
  assign w_push = (r_state == FETCH) && imem_ack && !redirect && (!w_full || w_pop);

  always_comb begin
    w_count_next = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_next = r_count + CNT_W'(1);
      2'b01:   w_count_next = r_count - CNT_W'(1);
      default: w_count_next = r_count;
    endcase
  end

  // WAIT_SPACE looks at the post-pop count so fetching resumes in the cycle
  // right after the slot frees up.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE: begin
        if (fetch_en) w_state_next = FETCH;
      end
      FETCH: begin
        if (imem_ack) begin
          if (w_count_next == FULL_CNT) w_state_next = WAIT_SPACE;
          else if (!fetch_en)           w_state_next = IDLE;
          else                          w_state_next = FETCH;
        end
      end
      WAIT_SPACE: begin
        if (w_count_next < FULL_CNT) w_state_next = fetch_en ? FETCH : IDLE;
      end
      default: w_state_next = IDLE;
    endcase
    if (redirect) w_state_next = fetch_en ? FETCH : IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_pc     <= '0;
      r_count  <= '0;
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      r_state <= w_state_next;
      if (redirect) begin
        r_pc     <= redirect_addr;
        r_count  <= '0;
        r_rd_ptr <= '0;
        r_wr_ptr <= '0;
      end else begin
        r_count <= w_count_next;
        if (w_push) begin
          r_pc     <= r_pc + ADDR_W'(1);
          r_wr_ptr <= ptr_inc(r_wr_ptr);
        end
        if (w_pop) r_rd_ptr <= ptr_inc(r_rd_ptr);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wr_ptr] <= imem_rdata;
  end

  assign imem_req  = (r_state == FETCH);
  assign imem_addr = r_pc;
  assign valid     = (r_count != '0);
  assign opcode    = r_mem[r_rd_ptr][15:12];
  assign operand   = r_mem[r_rd_ptr][11:0];
  assign idle      = (r_state == IDLE) && (r_count == '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Scoreboard bench for instr_fetch_unit: a memory responder queues each accepted
// word, a monitor checks every popped head against it, directed checks cover the rest.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_en;
  logic        imem_req;
  logic [7:0]  imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [3:0]  opcode;
  logic [11:0] operand;
  logic        valid;
  logic        ready;
  logic        redirect;
  logic [7:0]  redirect_addr;
  logic        idle;

  logic        ack_en;
  logic [15:0] exp_q[$];
  int          total = 0;
  int          bad   = 0;

  instr_fetch_unit #(.ADDR_W(8), .DEPTH(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .fetch_en     (fetch_en),
    .imem_req     (imem_req),
    .imem_addr    (imem_addr),
    .imem_ack     (imem_ack),
    .imem_rdata   (imem_rdata),
    .opcode       (opcode),
    .operand      (operand),
    .valid        (valid),
    .ready        (ready),
    .redirect     (redirect),
    .redirect_addr(redirect_addr),
    .idle         (idle)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h want=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    exp_q.delete();
  endtask

  // Memory: acks every request while enabled; word = {addr[3:0], 12'h000}
  initial begin
    imem_ack   = 1'b0;
    imem_rdata = '0;
    forever begin
      @(negedge clk);
      if (ack_en && imem_req === 1'b1) begin
        imem_ack   = 1'b1;
        imem_rdata = {imem_addr[3:0], 12'h000};
        if (!rst && !redirect) exp_q.push_back(imem_rdata);
      end else begin
        imem_ack = 1'b0;
      end
    end
  end

  // Monitor: every head accepted downstream must match the next expected word
  initial begin
    logic [15:0] w;
    forever begin
      @(negedge clk);
      if (valid === 1'b1 && ready === 1'b1 && rst === 1'b0) begin
        if (exp_q.size() == 0) begin
          check("unexpected_pop", 32'd1, 32'd0);
        end else begin
          w = exp_q.pop_front();
          check("mon_opcode", {28'd0, opcode}, {28'd0, w[15:12]});
          check("mon_operand", {20'd0, operand}, {20'd0, w[11:0]});
        end
      end
    end
  end

  initial begin
    rst = 1'b1; fetch_en = 1'b0; ready = 1'b0; redirect = 1'b0;
    redirect_addr = '0; ack_en = 1'b0;

    // Reset held two cycles, then released with fetch disabled
    tick(); tick();
    check("rst_req", imem_req, 0);
    check("rst_valid", valid, 0);
    check("rst_idle", idle, 1);
    check("rst_addr", imem_addr, 0);
    rst = 1'b0;
    exp_q.delete();
    repeat (5) tick();
    check("hold_req", imem_req, 0);
    check("hold_valid", valid, 0);
    check("hold_idle", idle, 1);
    check("hold_addr", imem_addr, 0);

    // Streaming
    ack_en = 1'b1; ready = 1'b1; fetch_en = 1'b1;
    tick();
    check("str_req", imem_req, 1);
    check("str_addr0", imem_addr, 0);
    check("str_valid0", valid, 0);
    for (int k = 0; k < 12; k++) begin
      tick();
      check("str_valid", valid, 1);
      check("str_opcode", opcode, k);
    end
    fetch_en = 1'b0;
    tick();
    check("str_stop_req", imem_req, 0);
    check("str_last_op", opcode, 4'hC);
    tick();
    check("str_empty", valid, 0);
    check("str_idle", idle, 1);

    // Backpressure
    do_reset();
    ready = 1'b0; ack_en = 1'b1; fetch_en = 1'b1;
    repeat (5) tick();
    check("bp_req", imem_req, 0);
    check("bp_addr", imem_addr, 8'h04);
    check("bp_valid", valid, 1);
    check("bp_op", opcode, 0);
    repeat (3) tick();
    check("bp_req_hold", imem_req, 0);
    check("bp_op_hold", opcode, 0);
    check("bp_addr_hold", imem_addr, 8'h04);
    ready = 1'b1;
    tick();
    ready = 1'b0;
    check("bp_pulse_op", opcode, 1);
    check("bp_pulse_req", imem_req, 1);
    check("bp_pulse_addr", imem_addr, 8'h04);
    tick();

    // Push and pop together at count 3
    ready = 1'b1;
    tick();
    check("pp_req_a", imem_req, 1);
    check("pp_addr_a", imem_addr, 8'h05);
    tick();
    check("pp_req_b", imem_req, 1);
    check("pp_addr_b", imem_addr, 8'h06);
    check("pp_op_b", opcode, 3);
    ready = 1'b0;
    tick();
    check("pp_full_req", imem_req, 0);
    check("pp_full_addr", imem_addr, 8'h07);
    check("pp_full_op", opcode, 3);
    fetch_en = 1'b0; ready = 1'b1;
    repeat (4) tick();
    check("pp_drain_valid", valid, 0);
    check("pp_drain_idle", idle, 1);
    check("pp_drain_left", exp_q.size(), 0);

    // Redirect with three entries queued, ack in the same cycle
    do_reset();
    ready = 1'b0; ack_en = 1'b1; fetch_en = 1'b1;
    repeat (4) tick();
    check("rd_pre_addr", imem_addr, 8'h03);
    check("rd_pre_valid", valid, 1);
    redirect = 1'b1; redirect_addr = 8'h80;
    #1;
    check("rd_cyc_valid", valid, 1);
    check("rd_cyc_op", opcode, 0);
    tick();
    redirect = 1'b0;
    exp_q.delete();
    check("rd_valid", valid, 0);
    check("rd_req", imem_req, 1);
    check("rd_addr", imem_addr, 8'h80);
    tick();
    check("rd_new_valid", valid, 1);
    check("rd_new_op", opcode, 0);
    check("rd_new_addr", imem_addr, 8'h81);

    // Wrap at the top of the address space
    redirect = 1'b1; redirect_addr = 8'hFF;
    tick();
    redirect = 1'b0;
    exp_q.delete();
    check("wr_valid", valid, 0);
    check("wr_addr_ff", imem_addr, 8'hFF);
    tick();
    check("wr_addr_00", imem_addr, 8'h00);
    check("wr_op", opcode, 4'hF);
    fetch_en = 1'b0;
    tick();
    ready = 1'b1;
    repeat (3) tick();
    check("wr_drain_valid", valid, 0);
    check("wr_drain_idle", idle, 1);
    check("wr_drain_left", exp_q.size(), 0);

    // fetch_en dropped while a request is outstanding
    do_reset();
    ack_en = 1'b0; fetch_en = 1'b1; ready = 1'b0;
    tick();
    check("os_req", imem_req, 1);
    fetch_en = 1'b0;
    repeat (2) tick();
    check("os_req_held", imem_req, 1);
    check("os_addr_held", imem_addr, 0);
    ack_en = 1'b1;
    tick();
    check("os_req_done", imem_req, 0);
    check("os_valid", valid, 1);
    check("os_idle", idle, 0);
    check("os_addr", imem_addr, 1);
    ready = 1'b1;
    tick();
    check("os_empty_idle", idle, 1);

    // Reset overrides redirect, ack and ready
    fetch_en = 1'b1; ack_en = 1'b1; ready = 1'b0;
    repeat (3) tick();
    rst = 1'b1; redirect = 1'b1; redirect_addr = 8'h55; ready = 1'b1;
    tick();
    check("ro_req", imem_req, 0);
    check("ro_addr", imem_addr, 0);
    check("ro_valid", valid, 0);
    check("ro_idle", idle, 1);
    rst = 1'b0; redirect = 1'b0; fetch_en = 1'b0;
    exp_q.delete();
    tick();
    check("ro_after_req", imem_req, 0);
    check("ro_after_valid", valid, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
INSTR_FETCH_UNIT -- requirements
Module: instr_fetch_unit

Interface
REQ-001 The module SHALL use one clock and a synchronous, active-high reset: clk rising edge only, rst sampled on that edge.
REQ-002 Parameters SHALL be:
- ADDR_W, default 8, instruction address width.
- DEPTH, default 4, instruction queue entries.
REQ-003 Ports SHALL be:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- fetch_en  in  1  permit new fetches.
- imem_req  out  1  instruction memory request.
- imem_addr  out  ADDR_W  fetch address (pc).
- imem_ack  in  1  memory data valid; sampled only while imem_req=1.
- imem_rdata  in  16  instruction word.
- opcode  out  4  head entry bits [15:12], to the control unit.
- operand  out  12  head entry bits [11:0].
- valid  out  1  queue non-empty.
- ready  in  1  downstream accepts head.
- redirect  in  1  branch/jump taken.
- redirect_addr  in  ADDR_W  new pc.
- idle  out  1  low-power hint.

Function
REQ-004 FSM states SHALL be IDLE, FETCH and WAIT_SPACE.
REQ-005 In IDLE, imem_req SHALL be 0; fetch_en=1 SHALL move the FSM to FETCH on the next edge.
REQ-006 In FETCH, imem_req SHALL be 1 and imem_addr SHALL equal pc, held stable until imem_ack=1.
REQ-007 On imem_ack in FETCH, the design SHALL:
- push imem_rdata into the queue;
- increment pc modulo 2^ADDR_W, so 0xFF wraps to 0x00.
REQ-008 After an ack, the next state SHALL be:
- WAIT_SPACE if the post-update count equals DEPTH;
- else IDLE if fetch_en=0;
- else FETCH, with a back-to-back request at the new pc in the next cycle.
REQ-009 Deasserting fetch_en while a request is outstanding SHALL NOT drop the request; the FSM SHALL go to IDLE only after the ack.
REQ-010 In WAIT_SPACE, imem_req SHALL be 0; once count<DEPTH the FSM SHALL go to FETCH if fetch_en=1, else IDLE.
REQ-011 Queue outputs SHALL be:
- valid = (count!=0), driven from registered state;
- opcode and operand taken from the head entry.
REQ-012 The head SHALL be popped when valid && ready.
REQ-013 While valid && !ready, opcode and operand SHALL hold stable.
REQ-014 A push and a pop in the same cycle SHALL leave count unchanged and preserve FIFO order.
REQ-015 Queue latency SHALL be one cycle: data acked in cycle N is visible on opcode/valid in cycle N+1 if the queue was empty.
REQ-016 redirect SHALL have highest priority and, on its edge, SHALL:
- set count=0;
- set pc=redirect_addr;
- discard any imem_ack in that cycle;
- set next state FETCH if fetch_en=1, else IDLE.
REQ-017 During the redirect cycle, valid and opcode SHALL still reflect the pre-flush queue; valid SHALL be 0 in the following cycle.
REQ-018 idle SHALL equal (state==IDLE && count==0).
REQ-019 Count SHALL never exceed DEPTH, and a pop on an empty queue SHALL have no effect.

Reset
REQ-020 While rst=1 on an edge, the design SHALL set:
- state=IDLE, pc=0, count=0;
- queue read/write pointers=0;
- imem_req=0, imem_addr=0, valid=0, idle=1.
REQ-021 rst SHALL override redirect, imem_ack and ready in the same cycle.
REQ-022 An ack arriving in the reset cycle SHALL be discarded.
REQ-023 After rst deasserts, fetching SHALL start only when fetch_en=1.

Verification
REQ-024 The bench SHALL cover these scenarios:
- Reset: rst=1 for 2 cycles, then released with fetch_en=0 -> imem_req=0, valid=0, idle=1, imem_addr=0x00 held indefinitely.
- Streaming: fetch_en=1, ready=1, memory acks every request with rdata={addr[3:0],12'h000} -> opcodes 0x0,0x1,...,0xB appear on consecutive cycles, first valid one cycle after first ack.
- Backpressure: ready=0, acks every cycle -> exactly 4 entries accepted, imem_req drops, imem_addr=0x04, opcode=0x0 held; one ready pulse -> opcode=0x1, imem_req=1 at 0x04 next cycle.
- Simultaneous push/pop at count=3 -> count stays 3, FSM stays FETCH, order preserved.
- Redirect with 3 entries queued to redirect_addr=0x80, ack in same cycle -> next cycle valid=0, imem_req=1, imem_addr=0x80, acked word absent.
- Wrap: redirect_addr=0xFF, ack -> next imem_addr=0x00.
